// File: rtl/free_list_pkg.sv
// Shared sizing for the physical-register free list and its helpers.
package free_list_pkg;

    localparam int PREG_NUM  = 128;
    localparam int AREG_NUM  = 32;
    localparam int SLOTS     = 4;
    localparam int TAG_W     = 7;
    localparam int PTR_W     = 8;
    localparam int INIT_FREE = PREG_NUM - AREG_NUM;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [PTR_W-1:0] ptr_t;

    function automatic ptr_t ptr_add(input ptr_t p, input logic [2:0] n);
        return p + ptr_t'(n);
    endfunction

endpackage

// File: rtl/free_list_compact.sv
// Four-slot popcount with exclusive prefix offsets (position of each slot among the set bits before it).
module free_list_compact
    import free_list_pkg::*;
(
    input  logic [SLOTS-1:0]      vld,
    output logic [2:0]            cnt,
    output logic [SLOTS-1:0][1:0] off
);

    logic [2:0] acc;

    always_comb begin
        acc = '0;
        off = '0;
        for (int i = 0; i < SLOTS; i++) begin
            off[i] = acc[1:0];
            acc    = acc + 3'(vld[i]);
        end
        cnt = acc;
    end

endmodule

// File: rtl/free_list.sv
// Physical-register free list: grants up to 4 tags per cycle, reclaims released tags, rewinds on flush.
// Grant is combinational from SpecHead; consumption happens on the edge only when every request fits.
module free_list
    import free_list_pkg::*;
(
    input  logic       Clk,
    input  logic       Rest,
    input  logic       FreeStop,
    input  logic       FreeFlash,
    input  logic       AllocReq1,
    input  logic       AllocReq2,
    input  logic       AllocReq3,
    input  logic       AllocReq4,
    output logic [6:0] AllocAddr1,
    output logic [6:0] AllocAddr2,
    output logic [6:0] AllocAddr3,
    output logic [6:0] AllocAddr4,
    output logic       AllocReady,
    input  logic       CommitAble1,
    input  logic       CommitAble2,
    input  logic       CommitAble3,
    input  logic       CommitAble4,
    input  logic       ReleaseAble1,
    input  logic       ReleaseAble2,
    input  logic       ReleaseAble3,
    input  logic       ReleaseAble4,
    input  logic [6:0] ReleaseAddr1,
    input  logic [6:0] ReleaseAddr2,
    input  logic [6:0] ReleaseAddr3,
    input  logic [6:0] ReleaseAddr4,
    output logic [7:0] FreeCount
);

    tag_t ent [PREG_NUM];
    ptr_t spec_head, cmt_head, tail;

    logic [SLOTS-1:0]      alloc_req, rel_able, rel_vld;
    tag_t                  rel_addr [SLOTS];
    tag_t                  grant_idx [SLOTS];
    logic [2:0]            alloc_cnt, rel_cnt, cmt_cnt;
    logic [SLOTS-1:0][1:0] alloc_off, rel_off;
    logic                  alloc_fire;

    assign alloc_req   = {AllocReq4, AllocReq3, AllocReq2, AllocReq1};
    assign rel_able    = {ReleaseAble4, ReleaseAble3, ReleaseAble2, ReleaseAble1};
    assign rel_addr[0] = ReleaseAddr1;
    assign rel_addr[1] = ReleaseAddr2;
    assign rel_addr[2] = ReleaseAddr3;
    assign rel_addr[3] = ReleaseAddr4;

    // P0 backs r0, so a release of tag 0 is never returned to the list.
    always_comb begin
        rel_vld = '0;
        for (int i = 0; i < SLOTS; i++)
            rel_vld[i] = rel_able[i] & (rel_addr[i] != '0);
    end

    assign cmt_cnt = 3'(CommitAble1) + 3'(CommitAble2) + 3'(CommitAble3) + 3'(CommitAble4);

    free_list_compact u_alloc_compact (
        .vld (alloc_req),
        .cnt (alloc_cnt),
        .off (alloc_off)
    );

    free_list_compact u_rel_compact (
        .vld (rel_vld),
        .cnt (rel_cnt),
        .off (rel_off)
    );

    // Idle slots look at their own slot index so the outputs stay a contiguous window when nothing asks.
    always_comb begin
        for (int i = 0; i < SLOTS; i++)
            grant_idx[i] = spec_head[TAG_W-1:0]
                         + tag_t'(alloc_req[i] ? alloc_off[i] : 2'(i));
    end

    assign AllocAddr1 = ent[grant_idx[0]];
    assign AllocAddr2 = ent[grant_idx[1]];
    assign AllocAddr3 = ent[grant_idx[2]];
    assign AllocAddr4 = ent[grant_idx[3]];

    assign FreeCount  = tail - spec_head;
    assign AllocReady = FreeCount >= ptr_t'(alloc_cnt);
    assign alloc_fire = AllocReady & ~FreeStop & ~FreeFlash;

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            for (int k = 0; k < PREG_NUM; k++)
                ent[k] <= (k < INIT_FREE) ? tag_t'(AREG_NUM + k) : '0;
        end else begin
            for (int i = 0; i < SLOTS; i++)
                if (rel_vld[i])
                    ent[tail[TAG_W-1:0] + tag_t'(rel_off[i])] <= rel_addr[i];
        end
    end

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            spec_head <= '0;
            cmt_head  <= '0;
            tail      <= ptr_t'(INIT_FREE);
        end else begin
            cmt_head <= ptr_add(cmt_head, cmt_cnt);
            tail     <= ptr_add(tail, rel_cnt);
            // Flush rewinds to the committed point, counting this cycle's commits.
            if (FreeFlash)
                spec_head <= ptr_add(cmt_head, cmt_cnt);
            else if (alloc_fire)
                spec_head <= ptr_add(spec_head, alloc_cnt);
        end
    end

endmodule

// File: tb/tb_free_list.sv
// Directed table-driven bench for free_list plus hand-written full/stall/wrap/reset sequences.
module tb_free_list;

    logic            Clk = 1'b0;
    logic            Rest = 1'b0;
    logic            stop = 1'b0, flash = 1'b0;
    logic [3:0]      req = '0, cmt = '0, rel = '0;
    logic [3:0][6:0] raddr = '0;
    logic [6:0]      aa [4];
    logic            rdy;
    logic [7:0]      fcnt;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    free_list dut (
        .Clk          (Clk),
        .Rest         (Rest),
        .FreeStop     (stop),
        .FreeFlash    (flash),
        .AllocReq1    (req[0]),
        .AllocReq2    (req[1]),
        .AllocReq3    (req[2]),
        .AllocReq4    (req[3]),
        .AllocAddr1   (aa[0]),
        .AllocAddr2   (aa[1]),
        .AllocAddr3   (aa[2]),
        .AllocAddr4   (aa[3]),
        .AllocReady   (rdy),
        .CommitAble1  (cmt[0]),
        .CommitAble2  (cmt[1]),
        .CommitAble3  (cmt[2]),
        .CommitAble4  (cmt[3]),
        .ReleaseAble1 (rel[0]),
        .ReleaseAble2 (rel[1]),
        .ReleaseAble3 (rel[2]),
        .ReleaseAble4 (rel[3]),
        .ReleaseAddr1 (raddr[0]),
        .ReleaseAddr2 (raddr[1]),
        .ReleaseAddr3 (raddr[2]),
        .ReleaseAddr4 (raddr[3]),
        .FreeCount    (fcnt)
    );

    typedef struct packed {
        logic [3:0]      req;
        logic            stop;
        logic            flash;
        logic [3:0]      cmt;
        logic [3:0]      rel;
        logic [3:0][6:0] raddr;
        logic            rdy;
        logic [3:0][6:0] addr;
        logic [7:0]      cnt;
    } vec_t;

    vec_t tbl [8];

    function automatic vec_t mkv(input logic [3:0] r, input logic s, input logic f,
                                 input logic [3:0] c, input logic [3:0] rl,
                                 input logic [27:0] ra, input logic rd,
                                 input logic [27:0] ad, input logic [7:0] n);
        vec_t v;
        v.req = r; v.stop = s; v.flash = f; v.cmt = c; v.rel = rl;
        v.raddr = ra; v.rdy = rd; v.addr = ad; v.cnt = n;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic s, input logic f,
                         input logic [3:0] c, input logic [3:0] rl, input logic [27:0] ra);
        req = r; stop = s; flash = f; cmt = c; rel = rl; raddr = ra;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    logic [6:0] q [$];
    logic [6:0] e;

    initial begin
        // Slot 1 is the lowest 7 bits of each packed address field.
        tbl[0] = mkv(4'b1111, 0, 0, 4'b0000, 4'b0000, '0, 1, {7'd35, 7'd34, 7'd33, 7'd32}, 8'd92);
        tbl[1] = mkv(4'b0001, 0, 0, 4'b0000, 4'b0000, '0, 1, {7'd0,  7'd0,  7'd0,  7'd36}, 8'd91);
        tbl[2] = mkv(4'b0101, 0, 0, 4'b0000, 4'b0000, '0, 1, {7'd0,  7'd38, 7'd0,  7'd37}, 8'd89);
        tbl[3] = mkv(4'b1111, 1, 0, 4'b0000, 4'b0000, '0, 1, {7'd42, 7'd41, 7'd40, 7'd39}, 8'd89);
        tbl[4] = mkv(4'b1111, 0, 0, 4'b0000, 4'b0000, '0, 1, {7'd42, 7'd41, 7'd40, 7'd39}, 8'd85);
        tbl[5] = mkv(4'b0000, 0, 0, 4'b0000, 4'b1111, {7'd51, 7'd0, 7'd50, 7'd0}, 1, '0, 8'd87);
        tbl[6] = mkv(4'b1111, 0, 1, 4'b1111, 4'b0000, '0, 1, {7'd46, 7'd45, 7'd44, 7'd43}, 8'd94);
        tbl[7] = mkv(4'b1000, 0, 0, 4'b0000, 4'b0000, '0, 1, {7'd36, 7'd0,  7'd0,  7'd0 }, 8'd93);

        // Reset state.
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_count", 32'(fcnt), 96);
        chk("reset_ready", 32'(rdy), 1);
        for (int j = 0; j < 4; j++) chk($sformatf("reset_addr%0d", j + 1), 32'(aa[j]), 32 + j);
        Rest = 1'b1;
        step();

        for (int v = 0; v < 8; v++) begin
            drive(tbl[v].req, tbl[v].stop, tbl[v].flash, tbl[v].cmt, tbl[v].rel, tbl[v].raddr);
            #2;
            chk($sformatf("v%0d_ready", v), 32'(rdy), 32'(tbl[v].rdy));
            for (int j = 0; j < 4; j++)
                if (tbl[v].req[j])
                    chk($sformatf("v%0d_addr%0d", v, j + 1), 32'(aa[j]), 32'(tbl[v].addr[j]));
            step();
            chk($sformatf("v%0d_count", v), 32'(fcnt), 32'(tbl[v].cnt));
        end
        drive('0, 0, 0, '0, '0, '0);

        // Asynchronous reset mid-operation.
        #2 Rest = 1'b0;
        #1;
        chk("midrst_count", 32'(fcnt), 96);
        for (int j = 0; j < 4; j++) chk($sformatf("midrst_addr%0d", j + 1), 32'(aa[j]), 32 + j);
        step();
        Rest = 1'b1;
        step();

        // Drain the whole list, then a blocked request with a same-cycle release.
        for (int c = 0; c < 24; c++) begin
            drive(4'b1111, 0, 0, '0, '0, '0);
            #2;
            for (int j = 0; j < 4; j++)
                chk($sformatf("drain%0d_addr%0d", c, j + 1), 32'(aa[j]), 32 + 4 * c + j);
            step();
        end
        chk("empty_count", 32'(fcnt), 0);
        drive(4'b0001, 0, 0, '0, 4'b0001, {7'd0, 7'd0, 7'd0, 7'd40});
        #2;
        chk("empty_ready", 32'(rdy), 0);
        step();
        rel = '0;
        raddr = '0;
        #1;
        chk("refill_ready", 32'(rdy), 1);
        chk("refill_addr1", 32'(aa[0]), 40);
        chk("refill_count", 32'(fcnt), 1);

        // Release 40 more tags so Tail crosses index 127, then allocate them all back in order.
        q.push_back(7'd40);
        req = '0;
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 4; j++) begin
                raddr[j] = 7'(60 + 4 * i + j);
                q.push_back(raddr[j]);
            end
            rel = 4'b1111;
            step();
        end
        drive('0, 0, 0, '0, '0, '0);
        #1;
        chk("wrap_fill_count", 32'(fcnt), 41);
        for (int i = 0; i < 10; i++) begin
            req = 4'b1111;
            #2;
            for (int j = 0; j < 4; j++) begin
                e = q.pop_front();
                chk($sformatf("wrap%0d_addr%0d", i, j + 1), 32'(aa[j]), 32'(e));
            end
            step();
        end
        req = '0;
        #1;
        chk("wrap_end_count", 32'(fcnt), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
